// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, absorbs the one-cycle imem latency and presents
// PC/instruction/valid to decode. Define FETCH_PERF_EN to add the fetch/stall counters.
module instr_fetch #(
  parameter int                 ADDR_W   = 8,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instruction,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  output logic              if_valid
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] mem_pc_q, mem_pc_d;
  logic              mem_vld_q, mem_vld_d;
  logic [DATA_W-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic              hold_vld_q, hold_vld_d;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  // Branch comes from the older instruction in execute, so it beats a decode jump.
  assign redirect    = branch_taken | jump;
  assign redirect_pc = branch_taken ? branch_target : jump_target;
  assign imem_addr   = fetch_pc_q;

  always_comb begin
    if_instr = '0;
    if_pc    = '0;
    if_valid = 1'b0;
    if (hold_vld_q) begin
      if_instr = hold_instr_q;
      if_pc    = hold_pc_q;
      if_valid = 1'b1;
    end else if (mem_vld_q) begin
      if_instr = imem_instruction;
      if_pc    = mem_pc_q;
      if_valid = 1'b1;
    end
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    mem_pc_d     = mem_pc_q;
    mem_vld_d    = mem_vld_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    hold_vld_d   = hold_vld_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      mem_vld_d  = 1'b0;
      hold_vld_d = 1'b0;
    end else if (stall) begin
      // fetch_pc is frozen, so imem re-reads it and mem_pc can track it every stalled edge.
      mem_pc_d = fetch_pc_q;
      if (!hold_vld_q && mem_vld_q) begin
        hold_instr_d = imem_instruction;
        hold_pc_d    = mem_pc_q;
        hold_vld_d   = 1'b1;
        mem_vld_d    = 1'b1;
      end else if (hold_vld_q) begin
        mem_vld_d = 1'b1;
      end
    end else begin
      hold_vld_d = 1'b0;
      mem_pc_d   = fetch_pc_q;
      mem_vld_d  = 1'b1;
      fetch_pc_d = fetch_pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      mem_pc_q     <= '0;
      mem_vld_q    <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      hold_vld_q   <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      mem_pc_q     <= mem_pc_d;
      mem_vld_q    <= mem_vld_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_vld_q   <= hold_vld_d;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (if_valid && !stall) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall)              perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: registered imem model with Imem[i] = i + 0x100,
// checks reset, free run, stall hold, redirects, PC wrap and async reset mid-stall.
module tb_instr_fetch;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              stall;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_instruction;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              if_valid;
`ifdef FETCH_PERF_EN
  logic [31:0]       perf_fetch_cnt;
  logic [31:0]       perf_stall_cnt;
`endif

  logic [DATA_W-1:0] imem [256];

  int errors = 0;
  int checks = 0;

  instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(8'h00)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .jump             (jump),
    .jump_target      (jump_target),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_addr        (imem_addr),
    .imem_instruction (imem_instruction),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_stall_cnt   (perf_stall_cnt),
`endif
    .if_valid         (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_instruction <= imem[imem_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] pc);
    chk({tag, ".valid"}, 64'(if_valid), 64'd1);
    chk({tag, ".pc"},    64'(if_pc),    64'(pc));
    chk({tag, ".instr"}, 64'(if_instr), 64'(32'h100 + 32'(pc)));
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, 64'(if_valid), 64'd0);
    chk({tag, ".pc"},    64'(if_pc),    64'd0);
    chk({tag, ".instr"}, 64'(if_instr), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h100 + 32'(i);
    imem_instruction = '0;
    rst = 1'b1;
    stall = 1'b0;
    jump = 1'b0;
    jump_target = '0;
    branch_taken = 1'b0;
    branch_target = '0;

    step();
    step();
    chk("rst.imem_addr", 64'(imem_addr), 64'd0);
    chk_bubble("rst");

    rst = 1'b0;
    chk_bubble("post_rst");
    for (int i = 0; i < 6; i++) begin
      step();
      chk_out($sformatf("run%0d", i), 8'(i));
    end

    // presenting pc 5: stall three edges
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("stall%0d", i), 8'd5);
    end
    stall = 1'b0;
    for (int i = 6; i <= 9; i++) begin
      step();
      chk_out($sformatf("resume%0d", i), 8'(i));
    end

    // presenting pc 9: jump to 0x40
    jump = 1'b1;
    jump_target = 8'h40;
    step();
    jump = 1'b0;
    chk_bubble("jump_bubble");
    step();
    chk_out("jump_t0", 8'h40);
    step();
    chk_out("jump_t1", 8'h41);

    // branch and jump together under stall: branch wins
    branch_taken = 1'b1;
    branch_target = 8'h20;
    jump = 1'b1;
    jump_target = 8'h40;
    stall = 1'b1;
    step();
    branch_taken = 1'b0;
    jump = 1'b0;
    stall = 1'b0;
    chk_bubble("br_bubble");
    step();
    chk_out("br_t0", 8'h20);
    step();
    chk_out("br_t1", 8'h21);

    // PC wrap
    jump = 1'b1;
    jump_target = 8'hFE;
    step();
    jump = 1'b0;
    chk_bubble("wrap_bubble");
    step();
    chk_out("wrap_fe", 8'hFE);
    step();
    chk_out("wrap_ff", 8'hFF);
    step();
    chk_out("wrap_00", 8'h00);
    step();
    chk_out("wrap_01", 8'h01);

    // async reset while holding
    stall = 1'b1;
    step();
    chk_out("hold0", 8'h01);
    step();
    chk_out("hold1", 8'h01);
    rst = 1'b1;
    #1;
    chk_bubble("async_rst");
    chk("async_rst.imem_addr", 64'(imem_addr), 64'd0);
`ifdef FETCH_PERF_EN
    chk("perf_fetch_rst", 64'(perf_fetch_cnt), 64'd0);
    chk("perf_stall_rst", 64'(perf_stall_cnt), 64'd0);
`endif
    step();
    rst = 1'b0;
    stall = 1'b0;
    chk_bubble("rerst_bubble");
    step();
    chk_out("rerst0", 8'h00);
    step();
    chk_out("rerst1", 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
